// File: rtl/rt_fpga_rst_pkg.sv
// rt_fpga_rst_pkg: shared state encoding, cause bit layout and width helper for the reset sequencer
package rt_fpga_rst_pkg;
  typedef enum logic [1:0] {ASSERT, RELEASE, RUN} rst_state_e;
  localparam int CAUSE_POR  = 0;
  localparam int CAUSE_LOCK = 1;
  localparam int CAUSE_BTN  = 2;
  localparam int CAUSE_SW   = 3;
  localparam int CAUSE_W    = 4;
  function automatic int cw(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rt_fpga_rst_debounce.sv
// rt_fpga_rst_debounce: 2-flop synchroniser plus stable-level debounce for the board button
module rt_fpga_rst_debounce
  import rt_fpga_rst_pkg::*;
#(
  parameter int CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic db,
  output logic rise
);
  localparam int CW = cw(CYCLES);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic flip;
  assign flip = (sync[1] != db) && cnt == CW'(CYCLES - 1);
  assign rise = flip & sync[1];
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      cnt  <= '0;
      db   <= 1'b0;
    end else begin
      sync <= {sync[0], din};
      cnt  <= (sync[1] == db || flip) ? '0 : cnt + 1'b1;
      if (flip) db <= sync[1];
    end
  end
endmodule

// File: rtl/rt_fpga_rst_seq.sv
// rt_fpga_rst_seq: qualifies PLL lock, button and software reset, then releases staggered active-low resets
module rt_fpga_rst_seq
  import rt_fpga_rst_pkg::*;
#(
  parameter int NUM_RST_OUT     = 2,
  parameter int MIN_ASSERT      = 64,
  parameter int RELEASE_GAP     = 16,
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   locked_i,
  input  logic                   btn_rst_i,
  input  logic                   sw_rst_req_i,
  input  logic                   cause_clr_i,
  output logic [NUM_RST_OUT-1:0] rst_no,
  output logic                   rst_done_o,
  output logic [CAUSE_W-1:0]     rst_cause_o
);
  localparam int AW = cw(MIN_ASSERT);
  localparam int GW = cw(RELEASE_GAP);
  localparam int IW = cw(NUM_RST_OUT);
  rst_state_e state, state_n;
  logic [1:0] lsync;
  logic btn_db, btn_rise, ok, abort, done_n;
  logic [AW-1:0] acnt, acnt_n;
  logic [GW-1:0] gcnt, gcnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [NUM_RST_OUT-1:0] rel_n;
  logic [CAUSE_W-1:0] cause_set;

  rt_fpga_rst_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk (clk_i),
    .rst (rst_i),
    .din (btn_rst_i),
    .db  (btn_db),
    .rise(btn_rise)
  );

  assign ok    = lsync[1] & ~btn_db;
  assign abort = ~ok | sw_rst_req_i;

  always_comb begin
    state_n = state;
    acnt_n  = '0;
    gcnt_n  = '0;
    idx_n   = idx;
    rel_n   = rst_no;
    done_n  = 1'b0;
    if (state == ASSERT) begin
      rel_n  = '0;
      acnt_n = abort ? '0 : acnt + 1'b1;
      if (!abort && acnt == AW'(MIN_ASSERT - 1)) begin
        state_n = RELEASE;
        acnt_n  = '0;
        idx_n   = '0;
        rel_n   = NUM_RST_OUT'(1);
      end
    end else if (abort) begin
      state_n = ASSERT;
      rel_n   = '0;
    end else if (state == RELEASE) begin
      gcnt_n = gcnt + 1'b1;
      if (gcnt == GW'(RELEASE_GAP - 1)) begin
        gcnt_n = '0;
        // releases are strictly in order, so rst_no is a thermometer code
        if (idx < IW'(NUM_RST_OUT - 1)) begin
          idx_n = idx + 1'b1;
          rel_n = (rst_no << 1) | NUM_RST_OUT'(1);
        end else begin
          state_n = RUN;
          done_n  = 1'b1;
        end
      end
    end else begin
      done_n = 1'b1;
    end
  end

  always_comb begin
    cause_set             = '0;
    cause_set[CAUSE_LOCK] = lsync[1] & ~lsync[0];
    cause_set[CAUSE_BTN]  = btn_rise;
    cause_set[CAUSE_SW]   = sw_rst_req_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ASSERT;
      lsync       <= '0;
      acnt        <= '0;
      gcnt        <= '0;
      idx         <= '0;
      rst_no      <= '0;
      rst_done_o  <= 1'b0;
      rst_cause_o <= CAUSE_W'(1 << CAUSE_POR);
    end else begin
      state       <= state_n;
      lsync       <= {lsync[0], locked_i};
      acnt        <= acnt_n;
      gcnt        <= gcnt_n;
      idx         <= idx_n;
      rst_no      <= rel_n;
      rst_done_o  <= done_n;
      rst_cause_o <= (cause_clr_i ? '0 : rst_cause_o) | cause_set;
    end
  end
endmodule
